rob_retire: RTL and testbench

In-order retirement stage directly downstream of the reorder buffer. It inspects the ROB head entry each cycle and pops it once its result is ready. It commits the result to the architectural register file and releases the rename mapping. On a branch or load mispredict it raises a multi-cycle pipeline flush with a redirect PC to fetch.

---
 rtl/rob_retire.sv | 131 +++++++++++++
 tb/tb_rob_retire.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_retire.sv
// In-order ROB head retirement with mispredict flush/redirect. head_deq is combinational;
// ARF/RAT writes, redirect and flush are registered (1 cycle). Head is held while not ready or flushing.
module rob_retire #(
  parameter int ROB_ID_WIDTH = 4,
  parameter int ARF_ID_WIDTH = 5,
  parameter int REG_WIDTH    = 32,
  parameter int PC_WIDTH     = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    head_valid,
  input  logic [ROB_ID_WIDTH-1:0] head_rob_id,
  input  logic                    head_dst_valid,
  input  logic [ARF_ID_WIDTH-1:0] head_dst_arf_id,
  input  logic                    head_reg_ready,
  input  logic [REG_WIDTH-1:0]    head_reg_data,
  input  logic                    head_br_mispredict,
  input  logic                    head_ld_mispredict,
  input  logic [PC_WIDTH-1:0]     head_pc,
  input  logic [PC_WIDTH-1:0]     head_redirect_pc,
  output logic                    head_deq,
  output logic                    arf_wr_en,
  output logic [ARF_ID_WIDTH-1:0] arf_wr_id,
  output logic [REG_WIDTH-1:0]    arf_wr_data,
  output logic                    rat_clr_en,
  output logic [ARF_ID_WIDTH-1:0] rat_clr_arf_id,
  output logic [ROB_ID_WIDTH-1:0] rat_clr_rob_id,
  output logic                    flush,
  output logic                    redirect_valid,
  output logic [PC_WIDTH-1:0]     redirect_pc,
  output logic [31:0]             retired_count
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  typedef struct packed {
    logic                    en;
    logic [ARF_ID_WIDTH-1:0] arf_id;
    logic [ROB_ID_WIDTH-1:0] rob_id;
    logic [REG_WIDTH-1:0]    data;
  } commit_t;

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_e     state;
  logic [3:0] flush_cnt;
  commit_t    commit_q;

  logic head_ready;
  logic retire;
  logic ld_mp;
  logic br_mp;
  logic mispredict;
  logic writes_dst;

  // Reset also gates the pop so the ROB never loses an entry while rst is high.
  always_comb begin
    head_ready = 1'b0;
    retire     = 1'b0;
    ld_mp      = 1'b0;
    br_mp      = 1'b0;
    mispredict = 1'b0;
    writes_dst = 1'b0;
    head_ready = ~rst & (state == RUN) & head_valid & head_reg_ready;
    retire     = head_ready & ~head_ld_mispredict;
    ld_mp      = head_ready & head_ld_mispredict;
    br_mp      = retire & head_br_mispredict;
    mispredict = ld_mp | br_mp;
    writes_dst = head_dst_valid & (head_dst_arf_id != '0);
  end

  assign head_deq       = head_ready;
  assign arf_wr_en      = commit_q.en;
  assign arf_wr_id      = commit_q.arf_id;
  assign arf_wr_data    = commit_q.data;
  assign rat_clr_en     = commit_q.en;
  assign rat_clr_arf_id = commit_q.arf_id;
  assign rat_clr_rob_id = commit_q.rob_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      flush_cnt      <= '0;
      flush          <= 1'b0;
      commit_q       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      retired_count  <= '0;
    end else begin
      commit_q.en <= retire & writes_dst;
      if (retire & writes_dst) begin
        commit_q.arf_id <= head_dst_arf_id;
        commit_q.rob_id <= head_rob_id;
        commit_q.data   <= head_reg_data;
      end

      // A replaying load re-fetches itself; a committed branch goes to its target.
      redirect_valid <= mispredict;
      if (mispredict) begin
        redirect_pc <= ld_mp ? head_pc : head_redirect_pc;
      end

      if (retire) begin
        retired_count <= retired_count + 32'd1;
      end

      case (state)
        RUN: begin
          if (mispredict) begin
            state     <= FLUSH;
            flush     <= 1'b1;
            flush_cnt <= FLUSH_LAST;
          end
        end
        FLUSH: begin
          if (flush_cnt == 4'd0) begin
            state <= RUN;
            flush <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rob_retire.sv
// Self-checking bench for rob_retire: vector table with a write scoreboard plus hand-written flush/reset sequences.
module tb_rob_retire;

  localparam int RW = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int PW = 32;
  localparam int FC = 2;
  localparam int NV = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          head_valid;
  logic [RW-1:0] head_rob_id;
  logic          head_dst_valid;
  logic [AW-1:0] head_dst_arf_id;
  logic          head_reg_ready;
  logic [DW-1:0] head_reg_data;
  logic          head_br_mispredict;
  logic          head_ld_mispredict;
  logic [PW-1:0] head_pc;
  logic [PW-1:0] head_redirect_pc;
  logic          head_deq;
  logic          arf_wr_en;
  logic [AW-1:0] arf_wr_id;
  logic [DW-1:0] arf_wr_data;
  logic          rat_clr_en;
  logic [AW-1:0] rat_clr_arf_id;
  logic [RW-1:0] rat_clr_rob_id;
  logic          flush;
  logic          redirect_valid;
  logic [PW-1:0] redirect_pc;
  logic [31:0]   retired_count;

  rob_retire #(
    .ROB_ID_WIDTH(RW), .ARF_ID_WIDTH(AW), .REG_WIDTH(DW), .PC_WIDTH(PW), .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk), .rst(rst),
    .head_valid(head_valid), .head_rob_id(head_rob_id),
    .head_dst_valid(head_dst_valid), .head_dst_arf_id(head_dst_arf_id),
    .head_reg_ready(head_reg_ready), .head_reg_data(head_reg_data),
    .head_br_mispredict(head_br_mispredict), .head_ld_mispredict(head_ld_mispredict),
    .head_pc(head_pc), .head_redirect_pc(head_redirect_pc),
    .head_deq(head_deq),
    .arf_wr_en(arf_wr_en), .arf_wr_id(arf_wr_id), .arf_wr_data(arf_wr_data),
    .rat_clr_en(rat_clr_en), .rat_clr_arf_id(rat_clr_arf_id), .rat_clr_rob_id(rat_clr_rob_id),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [RW-1:0] rob;
    logic          dv;
    logic [AW-1:0] dst;
    logic          rdy;
    logic [DW-1:0] data;
    logic          exp_deq;
    logic          exp_wr;
    logic          exp_ret;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0] id;
    logic [RW-1:0] rob;
    logic [DW-1:0] data;
  } wr_t;

  vec_t        vt[NV];
  wr_t         sb_q[$];
  wr_t         e;
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_count;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [RW-1:0] rob, input logic dv,
                       input logic [AW-1:0] dst, input logic rdy, input logic [DW-1:0] data,
                       input logic br, input logic ld, input logic [PW-1:0] pc,
                       input logic [PW-1:0] redir);
    head_valid         = v;
    head_rob_id        = rob;
    head_dst_valid     = dv;
    head_dst_arf_id    = dst;
    head_reg_ready     = rdy;
    head_reg_data      = data;
    head_br_mispredict = br;
    head_ld_mispredict = ld;
    head_pc            = pc;
    head_redirect_pc   = redir;
  endtask

  task automatic load_mispredict(input string tag, input logic br_too);
    @(negedge clk);
    drive(1'b1, 4'd6, 1'b1, 5'd3, 1'b1, 32'h1111_2222, br_too, 1'b1, 32'h120, 32'h999);
    #1 chk({tag, " deq"}, head_deq, 1'b1);
    @(posedge clk); #1;
    chk({tag, " arf_wr_en"}, arf_wr_en, 1'b0);
    chk({tag, " rat_clr_en"}, rat_clr_en, 1'b0);
    chk({tag, " redirect_valid"}, redirect_valid, 1'b1);
    chk({tag, " redirect_pc"}, redirect_pc, 32'h120);
    chk({tag, " flush1"}, flush, 1'b1);
    chk({tag, " count"}, retired_count, exp_count);
    @(negedge clk);
    drive(1'b1, 4'd7, 1'b1, 5'd4, 1'b1, 32'h5, 1'b0, 1'b0, 32'h124, 32'h0);
    #1 chk({tag, " deq in flush"}, head_deq, 1'b0);
    @(posedge clk); #1;
    chk({tag, " flush2"}, flush, 1'b1);
    chk({tag, " redirect one-shot"}, redirect_valid, 1'b0);
    @(posedge clk); #1;
    chk({tag, " flush end"}, flush, 1'b0);
    chk({tag, " no write in flush"}, arf_wr_en, 1'b0);
    @(negedge clk);
    drive(1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    vt[0]  = '{1'b1, 4'd3,  1'b1, 5'd5,  1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1};
    vt[1]  = '{1'b1, 4'd4,  1'b0, 5'd7,  1'b1, 32'h0000_00AA, 1'b1, 1'b0, 1'b1};
    vt[2]  = '{1'b1, 4'd5,  1'b1, 5'd0,  1'b1, 32'h0000_00BB, 1'b1, 1'b0, 1'b1};
    vt[3]  = '{1'b1, 4'd6,  1'b1, 5'd9,  1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 4'd6,  1'b1, 5'd9,  1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 4'd6,  1'b1, 5'd9,  1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 4'd6,  1'b1, 5'd9,  1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 4'd6,  1'b1, 5'd9,  1'b1, 32'hCAFE_0001, 1'b1, 1'b1, 1'b1};
    vt[8]  = '{1'b1, 4'd7,  1'b1, 5'd31, 1'b1, 32'hCAFE_0002, 1'b1, 1'b1, 1'b1};
    vt[9]  = '{1'b1, 4'd8,  1'b0, 5'd2,  1'b1, 32'hCAFE_0003, 1'b1, 1'b0, 1'b1};
    vt[10] = '{1'b1, 4'd15, 1'b1, 5'd12, 1'b1, 32'hCAFE_0004, 1'b1, 1'b1, 1'b1};

    rst = 1'b1;
    drive(1'b1, 4'd1, 1'b1, 5'd1, 1'b1, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0);
    exp_count = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset head_deq", head_deq, 1'b0);
    chk("reset arf_wr_en", arf_wr_en, 1'b0);
    chk("reset rat_clr_en", rat_clr_en, 1'b0);
    chk("reset flush", flush, 1'b0);
    chk("reset redirect_valid", redirect_valid, 1'b0);
    chk("reset redirect_pc", redirect_pc, 32'h0);
    chk("reset arf_wr_data", arf_wr_data, 32'h0);
    chk("reset retired_count", retired_count, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vt[i].v, vt[i].rob, vt[i].dv, vt[i].dst, vt[i].rdy, vt[i].data,
            1'b0, 1'b0, 32'h200 + 32'(i * 4), 32'h0);
      #1 chk($sformatf("vec%0d head_deq", i), head_deq, vt[i].exp_deq);
      if (vt[i].exp_wr) sb_q.push_back('{vt[i].dst, vt[i].rob, vt[i].data});
      if (vt[i].exp_ret) exp_count = exp_count + 32'd1;
      @(posedge clk); #1;
      chk($sformatf("vec%0d arf_wr_en", i), arf_wr_en, vt[i].exp_wr);
      chk($sformatf("vec%0d rat_clr_en", i), rat_clr_en, vt[i].exp_wr);
      chk($sformatf("vec%0d retired_count", i), retired_count, exp_count);
      if (arf_wr_en) begin
        chk($sformatf("vec%0d sb nonempty", i), sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk($sformatf("vec%0d arf_wr_id", i), arf_wr_id, e.id);
          chk($sformatf("vec%0d arf_wr_data", i), arf_wr_data, e.data);
          chk($sformatf("vec%0d rat_clr_arf_id", i), rat_clr_arf_id, e.id);
          chk($sformatf("vec%0d rat_clr_rob_id", i), rat_clr_rob_id, e.rob);
        end
      end
    end
    chk("sb drained", sb_q.size(), 0);

    // Branch mispredict: JAL x1 commits, redirect to 0x400, two flush cycles.
    @(negedge clk);
    drive(1'b1, 4'd9, 1'b1, 5'd1, 1'b1, 32'h104, 1'b1, 1'b0, 32'h100, 32'h400);
    #1 chk("br deq", head_deq, 1'b1);
    exp_count = exp_count + 32'd1;
    @(posedge clk); #1;
    chk("br arf_wr_en", arf_wr_en, 1'b1);
    chk("br arf_wr_id", arf_wr_id, 5'd1);
    chk("br arf_wr_data", arf_wr_data, 32'h104);
    chk("br rat_clr_rob_id", rat_clr_rob_id, 4'd9);
    chk("br redirect_valid", redirect_valid, 1'b1);
    chk("br redirect_pc", redirect_pc, 32'h400);
    chk("br flush1", flush, 1'b1);
    chk("br count", retired_count, exp_count);
    @(negedge clk);
    drive(1'b1, 4'd10, 1'b1, 5'd2, 1'b1, 32'h77, 1'b0, 1'b0, 32'h400, 32'h0);
    #1 chk("br deq in flush1", head_deq, 1'b0);
    @(posedge clk); #1;
    chk("br flush2", flush, 1'b1);
    chk("br redirect one-shot", redirect_valid, 1'b0);
    chk("br no write in flush", arf_wr_en, 1'b0);
    @(negedge clk);
    #1 chk("br deq in flush2", head_deq, 1'b0);
    @(posedge clk); #1;
    chk("br flush end", flush, 1'b0);
    @(negedge clk);
    #1 chk("br first run deq", head_deq, 1'b1);
    exp_count = exp_count + 32'd1;
    @(posedge clk); #1;
    chk("br first run write", arf_wr_en, 1'b1);
    chk("br first run id", arf_wr_id, 5'd2);
    chk("br first run count", retired_count, exp_count);
    @(negedge clk);
    drive(1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    load_mispredict("ld", 1'b0);
    load_mispredict("ld+br", 1'b1);

    // Reset asserted during the first flush cycle.
    @(negedge clk);
    drive(1'b1, 4'd11, 1'b1, 5'd4, 1'b1, 32'h55, 1'b1, 1'b0, 32'h300, 32'h500);
    @(posedge clk); #1;
    chk("rstf flush1", flush, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 4'd12, 1'b1, 5'd6, 1'b1, 32'h66, 1'b0, 1'b0, 32'h500, 32'h0);
    #1 chk("rstf deq in rst", head_deq, 1'b0);
    @(posedge clk); #1;
    exp_count = 32'd0;
    chk("rstf flush", flush, 1'b0);
    chk("rstf redirect_valid", redirect_valid, 1'b0);
    chk("rstf arf_wr_en", arf_wr_en, 1'b0);
    chk("rstf rat_clr_en", rat_clr_en, 1'b0);
    chk("rstf redirect_pc", redirect_pc, 32'h0);
    chk("rstf count", retired_count, exp_count);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rstf first deq", head_deq, 1'b1);
    exp_count = exp_count + 32'd1;
    @(posedge clk); #1;
    chk("rstf write", arf_wr_en, 1'b1);
    chk("rstf write data", arf_wr_data, 32'h66);
    chk("rstf count after", retired_count, exp_count);

    @(negedge clk);
    drive(1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
